// File: rtl/eq_pkg.sv
// Shared definitions for the biquad equalizer coefficient loader:
// loader state encoding, stage count, header field layout and the
// order in which coefficient words arrive in the stream.
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_e;

    // Number of equalizer stages; filter select values run 1..NUM_FILT.
    localparam int NUM_FILT = 5;
    localparam logic [2:0] FILT_LAST = 3'(NUM_FILT);

    // Header word layout: low bits carry the target index, the rest is ignored.
    localparam int         IDX_LSB       = 0;
    localparam int         IDX_W         = 3;
    localparam logic [2:0] IDX_BROADCAST = 3'd0;

    // Position of each coefficient within a set (word counter value).
    localparam logic [2:0] B0 = 3'd0;
    localparam logic [2:0] B1 = 3'd1;
    localparam logic [2:0] B2 = 3'd2;
    localparam logic [2:0] A1 = 3'd3;
    localparam logic [2:0] A2 = 3'd4;

endpackage

// File: rtl/eq_coef_loader.sv
// Coefficient programmer for the five-stage biquad equalizer.
// Takes a header word plus five coefficient words (b0, b1, b2, a1, a2),
// buffers the complete set, then strobes it into one stage or all stages.
// Optional build macro: EQ_COEF_LOADER_IDLE_WAIT_EN -- when defined, each
// write waits for the equalizer to report idle (i_eq_idle).
module eq_coef_loader
    import eq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_word,
    input  logic        i_word_valid,
    output logic        o_word_ready,
    input  logic        i_clear,
    input  logic        i_eq_idle,
    output logic        o_set_coef,
    output logic [2:0]  o_set_filt,
    output logic [31:0] o_b0,
    output logic [31:0] o_b1,
    output logic [31:0] o_b2,
    output logic [31:0] o_a1,
    output logic [31:0] o_a2,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;         // word index within the set
    logic [2:0]        tgt_q, tgt_d;         // header target for single mode
    logic              bcast_q, bcast_d;
    logic [4:0][31:0]  coll_q, coll_d;       // set being collected
    logic [4:0][31:0]  coef_q, coef_d;       // set presented to the equalizer
    logic              set_coef_q, set_coef_d;  // a write slot is armed
    logic [2:0]        set_filt_q, set_filt_d;  // also serves as filter counter
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              wr_gate;
    logic              write_fire;
    logic [IDX_W-1:0]  hdr_idx;

`ifdef EQ_COEF_LOADER_IDLE_WAIT_EN
    assign wr_gate = i_eq_idle;
`else
    logic unused_eq_idle;
    assign unused_eq_idle = i_eq_idle;
    assign wr_gate        = 1'b1;
`endif

    assign o_word_ready = (state_q == IDLE) || (state_q == COLLECT);
    assign accept       = i_word_valid && o_word_ready;
    assign hdr_idx      = i_word[IDX_LSB +: IDX_W];
    assign write_fire   = set_coef_q && wr_gate;

    // Next-state, collection and output register computation.
    always_comb begin
        // NOTE: every variable gets a default here so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        bcast_d    = bcast_q;
        coll_d     = coll_q;
        coef_d     = coef_q;
        set_coef_d = set_coef_q;
        set_filt_d = set_filt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (i_clear) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            set_coef_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (hdr_idx > FILT_LAST) begin
                            err_d = 1'b1;
                        end else begin
                            bcast_d = (hdr_idx == IDX_BROADCAST);
                            tgt_d   = hdr_idx;
                            cnt_d   = 3'd0;
                            state_d = COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        // NOTE: blocking update in always_comb, so coef_d below sees the final word.
                        coll_d[cnt_q] = i_word;
                        if (cnt_q == A2) begin
                            coef_d     = coll_d;
                            cnt_d      = 3'd0;
                            state_d    = WRITE;
                            set_coef_d = 1'b1;
                            set_filt_d = bcast_q ? 3'd1 : tgt_q;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    // A stalled slot simply holds; the pending target is retried.
                    if (write_fire) begin
                        if (!bcast_q || (set_filt_q == FILT_LAST)) begin
                            set_coef_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = DONE;
                        end else begin
                            set_filt_d = set_filt_q + 3'd1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            tgt_q      <= 3'd0;
            bcast_q    <= 1'b0;
            // NOTE: the buffers are plain flops with defined reset values, not RAM, so they are reset too.
            coll_q     <= '0;
            coef_q     <= '0;
            set_coef_q <= 1'b0;
            set_filt_q <= 3'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            bcast_q    <= bcast_d;
            coll_q     <= coll_d;
            coef_q     <= coef_d;
            set_coef_q <= set_coef_d;
            set_filt_q <= set_filt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign o_set_coef = write_fire;
    assign o_set_filt = set_filt_q;
    assign o_b0       = coef_q[B0];
    assign o_b1       = coef_q[B1];
    assign o_b2       = coef_q[B2];
    assign o_a1       = coef_q[A1];
    assign o_a2       = coef_q[A2];
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_eq_coef_loader.sv
// Self-checking bench for eq_coef_loader: directed sets from the test plan
// plus randomized sets, each compared against the expected write schedule
// derived from the header index. The idle-stall scenario is compiled only
// when EQ_COEF_LOADER_IDLE_WAIT_EN is defined.
module tb_eq_coef_loader;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_word = '0;
    logic        i_word_valid = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_eq_idle = 1'b1;
    logic        o_word_ready;
    logic        o_set_coef;
    logic [2:0]  o_set_filt;
    logic [31:0] o_b0, o_b1, o_b2, o_a1, o_a2;
    logic        o_busy, o_done, o_err;

    eq_coef_loader dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .i_clear      (i_clear),
        .i_eq_idle    (i_eq_idle),
        .o_set_coef   (o_set_coef),
        .o_set_filt   (o_set_filt),
        .o_b0         (o_b0),
        .o_b1         (o_b1),
        .o_b2         (o_b2),
        .o_a1         (o_a1),
        .o_a2         (o_a2),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [4:0][31:0] last_set = '0;   // last set fully written, as the outputs should show

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Move to just after the next rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Offer one word until accepted (bounded); returns just after the accepting edge.
    task automatic put_word(input logic [31:0] w);
        int t;
        bit acc;
        t   = 0;
        acc = 1'b0;
        i_word       = w;
        i_word_valid = 1'b1;
        while (!acc && t < 50) begin
            @(negedge i_clk);
            acc = o_word_ready;
            step();
            t++;
        end
        i_word_valid = 1'b0;
        if (!acc) check("word_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_coefs(input string tag, input logic [4:0][31:0] c);
        check({tag, "_b0"}, o_b0, c[0]);
        check({tag, "_b1"}, o_b1, c[1]);
        check({tag, "_b2"}, o_b2, c[2]);
        check({tag, "_a1"}, o_a1, c[3]);
        check({tag, "_a2"}, o_a2, c[4]);
    endtask

    // Send header + five coefficients, then check the write schedule:
    // targets are {1..5} for index 0, otherwise {idx}; one strobe per cycle
    // starting the cycle after the last word, optionally stalled for
    // stall_len cycles while the pending target equals stall_filt.
    task automatic run_set(input logic [2:0] idx, input logic [4:0][31:0] c,
                           input bit gaps, input int stall_filt, input int stall_len);
        int nw, k, cyc, stall;
        int tgt;
        bit stalled;
        put_word({29'($urandom), idx});
        for (int i = 0; i < 5; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            put_word(c[i]);
        end
        nw    = (idx == 3'd0) ? 5 : 1;
        k     = 0;
        cyc   = 0;
        stall = stall_len;
        while (k < nw && cyc < 40) begin
            tgt     = (idx == 3'd0) ? k + 1 : int'(idx);
            stalled = (stall > 0) && (tgt == stall_filt);
            i_eq_idle = !stalled;
            @(negedge i_clk);
            check("set_coef", {31'd0, o_set_coef}, {31'd0, !stalled});
            check("set_filt", {29'd0, o_set_filt}, 32'(tgt));
            check("busy_in_write", {31'd0, o_busy}, 32'd1);
            check("no_early_done", {31'd0, o_done}, 32'd0);
            if (!stalled) begin
                check_coefs("write", c);
                k++;
            end else begin
                stall--;
            end
            step();
            cyc++;
        end
        i_eq_idle = 1'b1;
        if (k < nw) check("write_timeout", 32'(k), 32'(nw));
        @(negedge i_clk);
        check("done_pulse", {31'd0, o_done}, 32'd1);
        check("no_strobe_at_done", {31'd0, o_set_coef}, 32'd0);
        step();
        @(negedge i_clk);
        check("done_single_cycle", {31'd0, o_done}, 32'd0);
        check("idle_after_done", {31'd0, o_busy}, 32'd0);
        check("ready_after_done", {31'd0, o_word_ready}, 32'd1);
        check_coefs("hold", c);
        last_set = c;
        step();
    endtask

    function automatic logic [4:0][31:0] rand_set();
        logic [4:0][31:0] c;
        for (int i = 0; i < 5; i++) c[i] = $urandom;
        return c;
    endfunction

    initial begin
        logic [4:0][31:0] c;
        logic [2:0] idx;

        // Reset state.
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_set_coef", {31'd0, o_set_coef}, 32'd0);
        check("rst_set_filt", {29'd0, o_set_filt}, 32'd0);
        check_coefs("rst", '0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_ready", {31'd0, o_word_ready}, 32'd1);
        step();
        i_rst_n = 1'b1;
        step();

        // Single set to filter 3, words every cycle.
        c = '0;
        c[0] = 32'h3F80_0000;
        run_set(3'd3, c, 1'b0, 0, 0);

        // Broadcast with b0 and a1 set.
        c = '0;
        c[0] = 32'h3F00_0000;
        c[3] = 32'hBF00_0000;
        run_set(3'd0, c, 1'b0, 0, 0);

        // Bad headers 6 and 7: error pulse only, then a normal set to filter 2.
        for (int h = 6; h <= 7; h++) begin
            put_word({29'($urandom), 3'(h)});
            @(negedge i_clk);
            check("err_pulse", {31'd0, o_err}, 32'd1);
            check("err_not_busy", {31'd0, o_busy}, 32'd0);
            check("err_no_strobe", {31'd0, o_set_coef}, 32'd0);
            check("err_ready", {31'd0, o_word_ready}, 32'd1);
            step();
            @(negedge i_clk);
            check("err_single_cycle", {31'd0, o_err}, 32'd0);
            step();
        end
        run_set(3'd2, rand_set(), 1'b0, 0, 0);

        // Abort after three coefficients; buses keep the last written set.
        put_word(32'h0000_0004);
        for (int i = 0; i < 3; i++) put_word($urandom);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        @(negedge i_clk);
        check("clear_idle", {31'd0, o_busy}, 32'd0);
        check("clear_ready", {31'd0, o_word_ready}, 32'd1);
        check("clear_no_strobe", {31'd0, o_set_coef}, 32'd0);
        check_coefs("clear_hold", last_set);
        step();
        run_set(3'd4, rand_set(), 1'b0, 0, 0);

`ifdef EQ_COEF_LOADER_IDLE_WAIT_EN
        // Broadcast with the equalizer busy for 3 cycles at filter 2.
        run_set(3'd0, rand_set(), 1'b0, 2, 3);
`endif

        // Randomized sets with random gaps between words.
        for (int n = 0; n < 20; n++) begin
            idx = 3'($urandom_range(0, 5));
            run_set(idx, rand_set(), 1'b1, 0, 0);
        end

        // Asynchronous reset in the middle of a broadcast write sequence.
        c = rand_set();
        put_word(32'h0000_0000);
        for (int i = 0; i < 5; i++) put_word(c[i]);
        @(negedge i_clk);
        check("pre_rst_strobe", {31'd0, o_set_coef}, 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_set_coef", {31'd0, o_set_coef}, 32'd0);
        check("arst_set_filt", {29'd0, o_set_filt}, 32'd0);
        check_coefs("arst", '0);
        check("arst_busy", {31'd0, o_busy}, 32'd0);
        check("arst_ready", {31'd0, o_word_ready}, 32'd1);
        step();
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("post_rst_no_strobe", {31'd0, o_set_coef}, 32'd0);
            check("post_rst_no_done", {31'd0, o_done}, 32'd0);
            step();
        end
        run_set(3'd5, rand_set(), 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eq_coef_loader.md
# eq_coef_loader

Coefficient programmer for the five-stage biquad equalizer: it is the initiator side of the equalizer's coefficient-set port. It accepts a 32-bit word stream (header plus five IEEE-754 single-precision coefficients) from the host/control path. It buffers one complete coefficient set, then drives the set-coefficient strobe, filter select and b0/b1/b2/a1/a2 buses into the equalizer, either for one filter or broadcast to all five.

## Interface
- NUM_FILT, 5, number of equalizer stages addressed; select field is 3 bits.
- i_clk  in  1  single clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_word  in  32  stream word: header or coefficient
- i_word_valid  in  1  i_word is valid this cycle
- o_word_ready  out  1  loader accepts a word this cycle
- i_clear  in  1  synchronous abort: discard partial set, return to IDLE
- i_eq_idle  in  1  equalizer idle (its o_valid); gates writes when the macro is enabled
- o_set_coef  out  1  one-cycle write strobe to equalizer
- o_set_filt  out  3  target filter 1..5
- o_b0, o_b1, o_b2, o_a1, o_a2  out  32 each  coefficient buses, held stable while o_set_coef is high
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse after the final write of a set
- o_err  out  1  one-cycle pulse on a bad header

## Operation
- Transfer: a word is taken when i_word_valid && o_word_ready. o_word_ready = 1 only in IDLE and COLLECT.
- Header word, bits [2:0] = index:
  - 1..5: single write to that filter.
  - 0: broadcast to filters 1..5.
  - 6, 7: word consumed, o_err pulses next cycle, stay IDLE.
  - Bits [31:3] are ignored.
- States:
  - IDLE: wait for header, then go to COLLECT with word counter = 0.
  - COLLECT: accepted words load b0, b1, b2, a1, a2 in order (counter 0..4). Counter 4 accepted goes to WRITE.
  - WRITE: one cycle per target. o_set_coef = 1 and o_set_filt = target. Single mode has 1 write; broadcast has 5 writes, filt 1, 2, 3, 4, 5 on consecutive cycles. After the last write, go to DONE.
  - DONE: o_done = 1 for one cycle, then IDLE.
- Coefficient registers hold their last values after DONE. Outputs show the last set written.
- i_clear has priority over everything except reset. From any state it goes to IDLE next cycle. o_set_coef is forced low that cycle and the counter is zeroed. Coefficient registers are not cleared.
- Reset mid-operation: everything goes to reset values immediately (asynchronous). No partial write is issued.

## Timing
- All outputs are registered except o_word_ready, which is decoded combinationally from the state.
- Reset values: o_set_coef 0, o_set_filt 0, all coefficient buses 32'h0, o_busy 0, o_done 0, o_err 0. o_word_ready is 1 after reset (IDLE).
- Last coefficient accepted at cycle N (write gate open):
  - single: o_set_coef high at N+1, o_done at N+2.
  - broadcast: o_set_coef high N+1..N+5, o_done at N+6.
- Header-to-first-coefficient: a coefficient can be accepted the cycle after the header.
- Minimum single-set time with continuous valid is 6 input cycles + 2. The next header can be accepted the cycle after o_done.
- o_err pulses exactly one cycle after the bad header is accepted.

## Configuration
- EQ_COEF_LOADER_IDLE_WAIT_EN defined:
  - Each WRITE cycle requires i_eq_idle = 1. Otherwise the loader stalls: o_set_coef stays 0 and o_set_filt holds the pending target.
  - Broadcast resumes at the same filter index when idle returns. Latency extends by the number of stalled cycles.
- Undefined: i_eq_idle is ignored and writes issue unconditionally at the cycles above.

## Structure
- Shared package eq_pkg holds:
  - the state enum (IDLE, COLLECT, WRITE, DONE)
  - NUM_FILT
  - header field constants: IDX_LSB = 0, IDX_W = 3, IDX_BROADCAST = 3'd0
  - coefficient order indices: B0 = 0 … A2 = 4
- No sub-module is needed. The collection register bank, the 3-bit word counter and the filter counter are inline.

## Test plan
- Single set, word ready every cycle:
  - Stimulus: header 3, then 3F800000, 0, 0, 0, 0 with i_eq_idle = 1.
  - Response: o_set_coef high for exactly one cycle with o_set_filt = 3, o_b0 = 3F800000, others 0. o_done pulses the next cycle.
- Broadcast:
  - Stimulus: header 0, then b0 = 3F000000, a1 = BF000000.
  - Response: five consecutive strobes with o_set_filt 1..5 and identical buses, then o_done.
- Bad header:
  - Stimulus: header 6.
  - Response: o_err pulses once, o_busy stays 0, no o_set_coef. A following valid header 2 is processed normally.
- Idle stall (macro defined):
  - Stimulus: broadcast with i_eq_idle dropped for 3 cycles at the write with filt 2.
  - Response: the strobe with filt 2 is delayed 3 cycles, no filter is skipped or repeated, and o_done comes 3 cycles later than nominal.
- Abort and reset:
  - i_clear after 3 coefficients: next cycle IDLE, no strobe. A fresh set then loads correctly.
  - i_rst_n low during WRITE: all outputs go to 0 immediately.
